// File: rtl/rv_rf_pkg.sv
// Register-file shared types: widths and the write-port bundle
// used by the WB stage, the write arbiter and the register file.
package rv_rf_pkg;

  localparam int NUM_REG        = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_WIDTH      = 32;

  typedef struct packed {
    logic                      we;
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [REG_WIDTH-1:0]      data;
  } rf_wr_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO holding long-latency results until the
// register-file write port is free.
module rf_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = wr_ptr == rd_ptr;
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB first, buffered long-latency
// results otherwise, plus busy scoreboard and starvation request.
module rf_write_arbiter
  import rv_rf_pkg::*;
#(
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wb_we,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic [REG_WIDTH-1:0]      wb_data,
  input  logic                      lu_valid,
  output logic                      lu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] lu_rd,
  input  logic [REG_WIDTH-1:0]      lu_data,
  input  logic                      iss_valid,
  input  logic [REG_ADDR_WIDTH-1:0] iss_rd,
  input  logic [REG_ADDR_WIDTH-1:0] chk_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] chk_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] chk_rd,
  output logic                      busy_stall,
  output logic                      stall_req,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr,
  output logic [REG_WIDTH-1:0]      rf_data
);

  localparam int EW = REG_ADDR_WIDTH + REG_WIDTH;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [EW-1:0]             head;
  logic [REG_ADDR_WIDTH-1:0] head_rd;
  logic [REG_WIDTH-1:0]      head_data;
  logic                      full;
  logic                      empty;
  logic                      wb_sel;
  logic                      pop;
  rf_wr_t                    wr;
  logic [NUM_REG-1:0]        busy;
  logic [NUM_REG-1:0]        busy_nxt;
  logic [CW-1:0]             starve_cnt;

  assign {head_rd, head_data} = head;
  assign lu_ready = !full;
  assign wb_sel   = wb_we && (wb_rd != '0);

  rf_wb_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (lu_valid),
    .din   ({lu_rd, lu_data}),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    wr  = '0;
    pop = 1'b0;
    if (wb_sel) begin
      wr = '{we: 1'b1, addr: wb_rd, data: wb_data};
    end else if (!empty) begin
      pop = 1'b1;
      wr  = '{we: head_rd != '0, addr: head_rd, data: head_data};
    end
    if (!rst_n) wr.we = 1'b0;
  end

  assign rf_we   = wr.we;
  assign rf_addr = wr.addr;
  assign rf_data = wr.data;

  // Set after clear so a same-cycle reissue keeps the register busy.
  always_comb begin
    busy_nxt = busy;
    if (pop) busy_nxt[head_rd] = 1'b0;
    if (iss_valid) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  assign busy_stall = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (pop || empty) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      if (pop) begin
        stall_req <= 1'b0;
      end else if (starve_cnt == LIMIT) begin
        stall_req <= 1'b1;
      end
    end
  end

endmodule
